// File: rtl/ysyx_22041071_pkg.sv
// Shared decode definitions: opcodes, ALU codes, operand selects and
// the control bundle carried from decode to EX.
package ysyx_22041071_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPW    = 7'b0111011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,  ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,  ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,  ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,  ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,  ALU_AND    = 5'd9,
    ALU_ADDW   = 5'd10, ALU_SUBW   = 5'd11,
    ALU_SLLW   = 5'd12, ALU_SRLW   = 5'd13,
    ALU_SRAW   = 5'd14, ALU_REMUW  = 5'd18,
    ALU_MUL    = 5'd19, ALU_MULH   = 5'd20,
    ALU_MULHSU = 5'd21, ALU_MULHU  = 5'd22,
    ALU_DIV    = 5'd23, ALU_DIVU   = 5'd24,
    ALU_REM    = 5'd25, ALU_REMU   = 5'd26,
    ALU_MULW   = 5'd27, ALU_DIVW   = 5'd28,
    ALU_DIVUW  = 5'd29, ALU_REMW   = 5'd30,
    ALU_INV    = 5'd31
  } alu_op_e;

  typedef enum logic [2:0] {
    SRC1_RS1  = 3'd0,
    SRC1_ZERO = 3'd4,
    SRC1_PC   = 3'd5
  } src1_e;

  typedef enum logic [2:0] {
    SRC2_RS2  = 3'd0,
    SRC2_IMM  = 3'd1,
    SRC2_FOUR = 3'd5
  } src2_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    alu_op_e    alu_op;
    src1_e      src1_sel;
    src2_e      src2_sel;
    logic       reg_wen;
    logic       mem_wen;
    logic       mem_ren;
    logic       wb_sel;
    logic       branch;
    logic       jalr;
    logic       illegal;
  } dec_ctrl_t;

  function automatic dec_ctrl_t ctrl_reset();
    dec_ctrl_t c;
    c = '0;
    c.alu_op = ALU_INV;
    return c;
  endfunction

  function automatic alu_op_e alu_base(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ysyx_22041071_imm_gen.sv
// Immediate generator: picks I/S/B/U/J by opcode and sign-extends
// the result to XLEN.
module ysyx_22041071_imm_gen
  import ysyx_22041071_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     ins,
  output logic [XLEN-1:0] imm
);

  logic [6:0]  opc;
  logic [31:0] imm32;

  assign opc = ins[6:0];

  always_comb begin
    imm32 = '0;
    unique case (1'b1)
      opc == OPC_OPIMM,
      opc == OPC_OPIMMW,
      opc == OPC_LOAD,
      opc == OPC_JALR:
        imm32 = {{20{ins[31]}}, ins[31:20]};
      opc == OPC_STORE:
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      opc == OPC_BRANCH:
        imm32 = {{19{ins[31]}}, ins[31], ins[7],
                 ins[30:25], ins[11:8], 1'b0};
      opc == OPC_LUI,
      opc == OPC_AUIPC:
        imm32 = {ins[31:12], 12'h000};
      opc == OPC_JAL:
        imm32 = {{11{ins[31]}}, ins[31], ins[19:12],
                 ins[20], ins[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  assign imm = {{(XLEN-32){imm32[31]}}, imm32};

endmodule

// File: rtl/ysyx_22041071_decode_stage.sv
// RV64I decode stage with main+skid output registers and JAL redirect.
// M-extension decode is enabled by YSYX_22041071_RV_M_EN.
module ysyx_22041071_decode_stage
  import ysyx_22041071_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64,
  parameter int ALU_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [31:0]       in_ins,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_ins,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic [ALU_W-1:0]  out_alu_op,
  output logic [2:0]        out_src1_sel,
  output logic [2:0]        out_src2_sel,
  output logic              out_reg_wen,
  output logic              out_mem_wen,
  output logic              out_mem_ren,
  output logic              out_wb_sel,
  output logic              out_branch,
  output logic              out_jalr,
  output logic              out_illegal,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc
);

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            ill;
  logic [XLEN-1:0] dec_imm;
  dec_ctrl_t       dec;

  assign opc = in_ins[6:0];
  assign f3  = in_ins[14:12];
  assign f7  = in_ins[31:25];

  ysyx_22041071_imm_gen #(.XLEN(XLEN)) u_imm (
    .ins (in_ins),
    .imm (dec_imm)
  );

  always_comb begin
    dec          = '0;
    dec.rs1      = in_ins[19:15];
    dec.rs2      = in_ins[24:20];
    dec.rd       = in_ins[11:7];
    dec.alu_op   = ALU_ADD;
    dec.src1_sel = SRC1_RS1;
    dec.src2_sel = SRC2_RS2;
    ill          = 1'b0;
    unique case (1'b1)
      opc == OPC_LUI: begin
        dec.src1_sel = SRC1_ZERO;
        dec.src2_sel = SRC2_IMM;
        dec.reg_wen  = 1'b1;
      end
      opc == OPC_AUIPC: begin
        dec.src1_sel = SRC1_PC;
        dec.src2_sel = SRC2_IMM;
        dec.reg_wen  = 1'b1;
      end
      opc == OPC_JAL: begin
        dec.src1_sel = SRC1_PC;
        dec.src2_sel = SRC2_FOUR;
        dec.reg_wen  = 1'b1;
      end
      opc == OPC_JALR: begin
        ill          = f3 != 3'd0;
        dec.src1_sel = SRC1_PC;
        dec.src2_sel = SRC2_FOUR;
        dec.reg_wen  = 1'b1;
        dec.jalr     = 1'b1;
      end
      opc == OPC_BRANCH: begin
        ill        = f3[2:1] == 2'b01;
        dec.branch = 1'b1;
        dec.alu_op = !f3[2] ? ALU_SUB
                   : (f3[1] ? ALU_SLTU : ALU_SLT);
      end
      opc == OPC_LOAD: begin
        ill          = f3 == 3'd7;
        dec.src2_sel = SRC2_IMM;
        dec.mem_ren  = 1'b1;
        dec.wb_sel   = 1'b1;
        dec.reg_wen  = 1'b1;
      end
      opc == OPC_STORE: begin
        ill          = f3[2];
        dec.src2_sel = SRC2_IMM;
        dec.mem_wen  = 1'b1;
      end
      opc == OPC_OPIMM: begin
        dec.src2_sel = SRC2_IMM;
        dec.reg_wen  = 1'b1;
        dec.alu_op   = alu_base(f3, f3 == 3'd5 && in_ins[30]);
        if (f3 == 3'd1)
          ill = in_ins[31:26] != 6'b000000;
        if (f3 == 3'd5)
          ill = in_ins[31:26] != 6'b000000
             && in_ins[31:26] != 6'b010000;
      end
      opc == OPC_OPIMMW: begin
        dec.src2_sel = SRC2_IMM;
        dec.reg_wen  = 1'b1;
        case (f3)
          3'd0: dec.alu_op = ALU_ADDW;
          3'd1: begin
            dec.alu_op = ALU_SLLW;
            ill        = f7 != F7_BASE;
          end
          3'd5: begin
            dec.alu_op = in_ins[30] ? ALU_SRAW : ALU_SRLW;
            ill        = f7 != F7_BASE && f7 != F7_ALT;
          end
          default: ill = 1'b1;
        endcase
      end
      opc == OPC_OP: begin
        dec.reg_wen = 1'b1;
        if (f7 == F7_BASE)
          dec.alu_op = alu_base(f3, 1'b0);
        else if (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5))
          dec.alu_op = alu_base(f3, 1'b1);
`ifdef YSYX_22041071_RV_M_EN
        else if (f7 == F7_MUL)
          dec.alu_op = alu_op_e'(5'd19 + {2'b00, f3});
`endif
        else
          ill = 1'b1;
      end
      opc == OPC_OPW: begin
        dec.reg_wen = 1'b1;
        ill         = 1'b1;
        if (f7 == F7_BASE) begin
          ill = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5);
          dec.alu_op = f3 == 3'd0 ? ALU_ADDW
                     : (f3 == 3'd1 ? ALU_SLLW : ALU_SRLW);
        end else if (f7 == F7_ALT) begin
          ill = !(f3 == 3'd0 || f3 == 3'd5);
          dec.alu_op = f3 == 3'd0 ? ALU_SUBW : ALU_SRAW;
        end
`ifdef YSYX_22041071_RV_M_EN
        else if (f7 == F7_MUL) begin
          ill = 1'b0;
          case (f3)
            3'd0:    dec.alu_op = ALU_MULW;
            3'd4:    dec.alu_op = ALU_DIVW;
            3'd5:    dec.alu_op = ALU_DIVUW;
            3'd6:    dec.alu_op = ALU_REMW;
            3'd7:    dec.alu_op = ALU_REMUW;
            default: ill = 1'b1;
          endcase
        end
`endif
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec.illegal = 1'b1;
      dec.alu_op  = ALU_INV;
      dec.reg_wen = 1'b0;
      dec.mem_wen = 1'b0;
      dec.mem_ren = 1'b0;
      dec.branch  = 1'b0;
      dec.jalr    = 1'b0;
      dec.wb_sel  = 1'b0;
    end
    if (dec.rd == 5'd0)
      dec.reg_wen = 1'b0;
  end

  logic              main_valid_q, main_valid_d;
  logic [ADDR_W-1:0] main_pc_q, main_pc_d;
  logic [31:0]       main_ins_q, main_ins_d;
  logic [XLEN-1:0]   main_imm_q, main_imm_d;
  dec_ctrl_t         main_ctrl_q, main_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]       skid_ins_q, skid_ins_d;
  logic [XLEN-1:0]   skid_imm_q, skid_imm_d;
  dec_ctrl_t         skid_ctrl_q, skid_ctrl_d;
  logic              accept;
  logic              drain;

  assign accept = in_valid & ~skid_valid_q & ~flush & ~reset;
  assign drain  = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_ins_d   = main_ins_q;
    main_imm_d   = main_imm_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_ins_d   = skid_ins_q;
    skid_imm_d   = skid_imm_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      // skid is older than anything at the input, so it goes first
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_pc_d    = skid_pc_q;
        main_ins_d   = skid_ins_q;
        main_imm_d   = skid_imm_q;
        main_ctrl_d  = skid_ctrl_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_pc_d   = in_pc;
          main_ins_d  = in_ins;
          main_imm_d  = dec_imm;
          main_ctrl_d = dec;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = in_pc;
      skid_ins_d   = in_ins;
      skid_imm_d   = dec_imm;
      skid_ctrl_d  = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= '0;
      main_ins_q   <= '0;
      main_imm_q   <= '0;
      main_ctrl_q  <= ctrl_reset();
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_ins_q   <= '0;
      skid_imm_q   <= '0;
      skid_ctrl_q  <= ctrl_reset();
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_ins_q   <= main_ins_d;
      main_imm_q   <= main_imm_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_ins_q   <= skid_ins_d;
      skid_imm_q   <= skid_imm_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end

  assign in_ready       = ~skid_valid_q;
  assign out_valid      = main_valid_q;
  assign out_pc         = main_pc_q;
  assign out_ins        = main_ins_q;
  assign out_imm        = main_imm_q;
  assign out_rs1        = main_ctrl_q.rs1;
  assign out_rs2        = main_ctrl_q.rs2;
  assign out_rd         = main_ctrl_q.rd;
  assign out_alu_op     = ALU_W'(main_ctrl_q.alu_op);
  assign out_src1_sel   = main_ctrl_q.src1_sel;
  assign out_src2_sel   = main_ctrl_q.src2_sel;
  assign out_reg_wen    = main_ctrl_q.reg_wen;
  assign out_mem_wen    = main_ctrl_q.mem_wen;
  assign out_mem_ren    = main_ctrl_q.mem_ren;
  assign out_wb_sel     = main_ctrl_q.wb_sel;
  assign out_branch     = main_ctrl_q.branch;
  assign out_jalr       = main_ctrl_q.jalr;
  assign out_illegal    = main_ctrl_q.illegal;
  assign redirect_valid = accept & (opc == OPC_JAL);
  assign redirect_pc    = in_pc + ADDR_W'(dec_imm);

endmodule
